// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared widths, stall-vector bit indices and FSM encoding for pipe_ctrl
package pipe_ctrl_pkg;

  // Bus widths used throughout the pipeline
  localparam int MemAddrW  = 32;
  localparam int StallBusW = 6;

  // Stall vector bit positions, one per pipeline register
  localparam int StallPC  = 0;
  localparam int StallIF  = 1;
  localparam int StallID  = 2;
  localparam int StallEX  = 3;
  localparam int StallMEM = 4;
  localparam int StallWB  = 5;

  // Fetch-discard tracker states
  typedef enum logic {
    CtrlIdle    = 1'b0,
    CtrlDiscard = 1'b1
  } ctrl_state_e;

  // Stalling a stage also stalls everything upstream of it, so the vector is
  // a contiguous mask of bits PC..stage inclusive.
  function automatic logic [StallBusW-1:0] stall_upto(input int unsigned stage);
    logic [StallBusW-1:0] mask;
    mask = '0;
    for (int unsigned k = 0; k < StallBusW; k++) begin
      if (k <= stage) begin
        mask[k] = 1'b1;
      end
    end
    return mask;
  endfunction

  // Minimum hold applied while a wrong-path fetch is still in flight
  localparam logic [StallBusW-1:0] StallFetchHold = 6'b000011;

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// rtl/pipe_ctrl_perf_cnt.sv - 32-bit wrapping event counter with enable
module pipe_ctrl_perf_cnt
  import pipe_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        en_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // Next value: advance by one when enabled, wrapping naturally at 2^32
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = count_q + 32'd1;
    end
  end

  // Counter register, cleared immediately on reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with fetch-discard tracking and perf counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall_req_if,
  input  logic                 stall_req_id,
  input  logic                 stall_req_ex,
  input  logic                 stall_req_mem,
  input  logic                 jump_i,
  input  logic [MemAddrW-1:0]  jump_target_i,
  input  logic                 if_busy_i,
  input  logic                 if_done_i,
  output logic [StallBusW-1:0] stall_o,
  output logic                 flush_o,
  output logic                 pc_redirect_o,
  output logic [MemAddrW-1:0]  pc_target_o,
  output logic                 if_discard_o,
  output logic [31:0]          stall_cycles_o,
  output logic [31:0]          flush_count_o
);

  ctrl_state_e state_q;
  ctrl_state_e state_d;

  logic                 accept;
  logic                 in_discard;
  logic [StallBusW-1:0] req_vec;

  // A jump can only be taken when EX and MEM are both free to advance;
  // otherwise the pipe holds it in EX and it is presented again later.
  assign accept     = jump_i && !stall_req_ex && !stall_req_mem;
  assign in_discard = (state_q == CtrlDiscard);

  // Priority encode the per-stage requests: the furthest-downstream stage wins
  always_comb begin
    req_vec = '0;
    if (stall_req_mem) begin
      req_vec = stall_upto(StallMEM);
    end else if (stall_req_ex) begin
      req_vec = stall_upto(StallEX);
    end else if (stall_req_id) begin
      req_vec = stall_upto(StallID);
    end else if (stall_req_if) begin
      req_vec = stall_upto(StallIF);
    end
  end

  // Output decode and discard-tracker next state
  always_comb begin
    stall_o       = '0;
    flush_o       = 1'b0;
    pc_redirect_o = 1'b0;
    pc_target_o   = '0;
    if_discard_o  = 1'b0;
    state_d       = state_q;

    if (accept) begin
      // IF/ID requests belong to the wrong path and are dropped; only an
      // outstanding wrong-path fetch still needs PC and IF held.
      stall_o       = in_discard ? StallFetchHold : '0;
      flush_o       = 1'b1;
      pc_redirect_o = 1'b1;
      pc_target_o   = jump_target_i;
    end else begin
      stall_o = req_vec | (in_discard ? StallFetchHold : '0);
    end

    // A returning word is dropped if it was fetched down the abandoned path,
    // including the case where it lands on the accept cycle itself.
    if_discard_o = if_done_i && (accept || in_discard);

    unique case (state_q)
      CtrlIdle: begin
        if (accept && if_busy_i && !if_done_i) begin
          state_d = CtrlDiscard;
        end
      end
      CtrlDiscard: begin
        // A further accept only retargets the PC; the same fetch is still owed.
        if (if_done_i) begin
          state_d = CtrlIdle;
        end
      end
      default: state_d = CtrlIdle;
    endcase

    // Reset silences every control output immediately, not just at the edge
    if (reset) begin
      stall_o       = '0;
      flush_o       = 1'b0;
      pc_redirect_o = 1'b0;
      pc_target_o   = '0;
      if_discard_o  = 1'b0;
    end
  end

  // Discard-tracker state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= CtrlIdle;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_ctrl_perf_cnt u_stall_cnt (
    .clock   (clock),
    .reset   (reset),
    .en_i    (|stall_o),
    .count_o (stall_cycles_o)
  );

  pipe_ctrl_perf_cnt u_flush_cnt (
    .clock   (clock),
    .reset   (reset),
    .en_i    (flush_o),
    .count_o (flush_count_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall_req_if, stall_req_id, stall_req_ex, stall_req_mem;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic        if_busy_i, if_done_i;
  logic [5:0]  stall_o;
  logic        flush_o, pc_redirect_o, if_discard_o;
  logic [31:0] pc_target_o, stall_cycles_o, flush_count_o;

  pipe_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .stall_req_if   (stall_req_if),
    .stall_req_id   (stall_req_id),
    .stall_req_ex   (stall_req_ex),
    .stall_req_mem  (stall_req_mem),
    .jump_i         (jump_i),
    .jump_target_i  (jump_target_i),
    .if_busy_i      (if_busy_i),
    .if_done_i      (if_done_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .pc_redirect_o  (pc_redirect_o),
    .pc_target_o    (pc_target_o),
    .if_discard_o   (if_discard_o),
    .stall_cycles_o (stall_cycles_o),
    .flush_count_o  (flush_count_o)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  // Reference model state: whether a wrong-path fetch is owed, and event tallies
  bit          m_owed;
  int unsigned m_stalls;
  int unsigned m_flushes;

  typedef struct {
    logic        sif, sid, sex, smem, jmp;
    logic [31:0] tgt;
    logic        busy, done;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_tgt;
    logic        e_disc;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic sif, sid, sex, smem, jmp, input logic [31:0] tgt,
                       input logic busy, done);
    stall_req_if  = sif;
    stall_req_id  = sid;
    stall_req_ex  = sex;
    stall_req_mem = smem;
    jump_i        = jmp;
    jump_target_i = tgt;
    if_busy_i     = busy;
    if_done_i     = done;
  endtask

  // Expected outputs from the stage-priority rules with plain arithmetic
  task automatic model_eval(output logic [5:0] s, output logic f, output logic [31:0] t,
                            output logic d);
    int  stage;
    bit  acc;
    acc   = jump_i && !stall_req_ex && !stall_req_mem;
    stage = stall_req_mem ? 4 : stall_req_ex ? 3 : stall_req_id ? 2 : stall_req_if ? 1 : 0;
    if (acc) stage = 0;
    s = (stage == 0) ? 6'd0 : 6'((1 << (stage + 1)) - 1);
    if (m_owed) s = s | 6'b000011;
    f = acc;
    t = acc ? jump_target_i : 32'd0;
    d = if_done_i && (acc || m_owed);
  endtask

  task automatic model_tick();
    logic [5:0]  s;
    logic        f, d;
    logic [31:0] t;
    model_eval(s, f, t, d);
    if (s != 0) m_stalls++;
    if (f) m_flushes++;
    if (!m_owed) m_owed = f && if_busy_i && !if_done_i;
    else if (if_done_i) m_owed = 1'b0;
  endtask

  task automatic model_check(input string nm);
    logic [5:0]  s;
    logic        f, d;
    logic [31:0] t;
    model_eval(s, f, t, d);
    chk({nm, ".stall"},  {26'd0, stall_o}, {26'd0, s});
    chk({nm, ".flush"},  {31'd0, flush_o}, {31'd0, f});
    chk({nm, ".redir"},  {31'd0, pc_redirect_o}, {31'd0, f});
    chk({nm, ".target"}, pc_target_o, t);
    chk({nm, ".disc"},   {31'd0, if_discard_o}, {31'd0, d});
    chk({nm, ".scnt"},   stall_cycles_o, m_stalls);
    chk({nm, ".fcnt"},   flush_count_o, m_flushes);
  endtask

  // Inputs applied shortly after posedge; check at negedge; model advances at posedge
  task automatic step_model(input string nm);
    @(negedge clock);
    model_check(nm);
    @(posedge clock);
    model_tick();
    #1;
  endtask

  task automatic step_expect(input string nm, input logic [5:0] es, input logic ef,
                             input logic [31:0] et, input logic ed);
    @(negedge clock);
    chk({nm, ".stall"},  {26'd0, stall_o}, {26'd0, es});
    chk({nm, ".flush"},  {31'd0, flush_o}, {31'd0, ef});
    chk({nm, ".redir"},  {31'd0, pc_redirect_o}, {31'd0, ef});
    chk({nm, ".target"}, pc_target_o, et);
    chk({nm, ".disc"},   {31'd0, if_discard_o}, {31'd0, ed});
    @(posedge clock);
    model_tick();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 32'd0, 0, 0);
    m_owed = 1'b0; m_stalls = 0; m_flushes = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
  endtask

  initial begin
    int unsigned base;
    vecs[0]  = '{0, 0, 0, 0, 0, 32'h0,         0, 0, 6'b000000, 0, 32'h0,         0};
    vecs[1]  = '{1, 0, 0, 0, 0, 32'h0,         0, 0, 6'b000011, 0, 32'h0,         0};
    vecs[2]  = '{1, 1, 0, 0, 0, 32'h0,         0, 0, 6'b000111, 0, 32'h0,         0};
    vecs[3]  = '{0, 1, 1, 0, 0, 32'h0,         0, 0, 6'b001111, 0, 32'h0,         0};
    vecs[4]  = '{1, 0, 1, 1, 0, 32'h0,         0, 0, 6'b011111, 0, 32'h0,         0};
    vecs[5]  = '{0, 0, 0, 0, 1, 32'h0000_1000, 0, 0, 6'b000000, 1, 32'h0000_1000, 0};
    vecs[6]  = '{1, 1, 0, 0, 1, 32'hA5A5_0004, 0, 0, 6'b000000, 1, 32'hA5A5_0004, 0};
    vecs[7]  = '{0, 0, 0, 1, 1, 32'h0000_1234, 0, 0, 6'b011111, 0, 32'h0,         0};
    vecs[8]  = '{0, 0, 1, 0, 1, 32'h0000_5678, 0, 0, 6'b001111, 0, 32'h0,         0};
    vecs[9]  = '{0, 0, 0, 0, 0, 32'h0,         0, 1, 6'b000000, 0, 32'h0,         0};
    vecs[10] = '{0, 0, 0, 0, 1, 32'h0000_0040, 1, 1, 6'b000000, 1, 32'h0000_0040, 1};
    vecs[11] = '{0, 0, 0, 0, 0, 32'h0,         1, 1, 6'b000000, 0, 32'h0,         0};

    do_reset();
    @(negedge clock);
    chk("reset.stall", {26'd0, stall_o}, 32'd0);
    chk("reset.scnt", stall_cycles_o, 32'd0);
    chk("reset.fcnt", flush_count_o, 32'd0);
    @(posedge clock); #1;

    // Table vectors, each valid from the IDLE state
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].sif, vecs[i].sid, vecs[i].sex, vecs[i].smem, vecs[i].jmp,
            vecs[i].tgt, vecs[i].busy, vecs[i].done);
      step_expect($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_flush,
                  vecs[i].e_tgt, vecs[i].e_disc);
    end
    drive(0, 0, 0, 0, 0, 32'd0, 0, 0);
    step_model("after_vec");

    // Priority sequence: stall counter advances by exactly two
    do_reset();
    base = stall_cycles_o;
    drive(1, 0, 0, 1, 0, 32'd0, 0, 0); step_expect("prio.mem", 6'b011111, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 32'd0, 0, 0); step_expect("prio.if",  6'b000011, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 32'd0, 0, 0); step_expect("prio.none", 6'b000000, 0, 0, 0);
    chk("prio.scnt", stall_cycles_o, base + 2);

    // Plain jump
    do_reset();
    drive(0, 0, 0, 0, 1, 32'h0000_1000, 0, 0); step_expect("jmp", 6'b0, 1, 32'h1000, 0);
    drive(0, 0, 0, 0, 0, 32'd0, 0, 0);         step_expect("jmp.after", 6'b0, 0, 0, 0);
    chk("jmp.fcnt", flush_count_o, 32'd1);

    // Held jump under an EX stall
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 1, 0, 1, 32'h0000_2000, 0, 0);
      step_expect($sformatf("held%0d", c), 6'b001111, 0, 0, 0);
    end
    drive(0, 0, 0, 0, 1, 32'h0000_2000, 0, 0); step_expect("held.go", 6'b0, 1, 32'h2000, 0);
    drive(0, 0, 0, 0, 0, 32'd0, 0, 0);         step_expect("held.after", 6'b0, 0, 0, 0);
    chk("held.fcnt", flush_count_o, 32'd1);
    chk("held.scnt", stall_cycles_o, 32'd3);

    // Discard of an in-flight wrong-path fetch
    do_reset();
    drive(0, 0, 0, 0, 1, 32'h0000_3000, 1, 0); step_expect("disc.acc", 6'b0, 1, 32'h3000, 0);
    drive(0, 0, 0, 0, 0, 32'd0, 1, 0);         step_expect("disc.w1", 6'b000011, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 32'd0, 1, 0);         step_expect("disc.w2", 6'b000011, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 32'd0, 1, 1);         step_expect("disc.done", 6'b000011, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 32'd0, 1, 1);         step_expect("disc.next", 6'b0, 0, 0, 0);

    // Second accept while still owed: retarget, hold PC/IF
    do_reset();
    drive(0, 0, 0, 0, 1, 32'h0000_4000, 1, 0); step_expect("re.acc1", 6'b0, 1, 32'h4000, 0);
    drive(0, 1, 0, 0, 1, 32'h0000_5000, 1, 0); step_expect("re.acc2", 6'b000011, 1, 32'h5000, 0);
    drive(0, 0, 0, 0, 0, 32'd0, 1, 1);         step_expect("re.done", 6'b000011, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 32'd0, 1, 1);         step_expect("re.next", 6'b0, 0, 0, 0);

    // Async reset in the middle of DISCARD, between clock edges
    do_reset();
    drive(0, 0, 0, 0, 1, 32'h0000_6000, 1, 0);
    step_model("rst.acc");
    drive(1, 1, 0, 0, 0, 32'd0, 1, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst.stall", {26'd0, stall_o}, 32'd0);
    chk("rst.disc", {31'd0, if_discard_o}, 32'd0);
    chk("rst.flush", {31'd0, flush_o}, 32'd0);
    chk("rst.scnt", stall_cycles_o, 32'd0);
    chk("rst.fcnt", flush_count_o, 32'd0);
    m_owed = 1'b0; m_stalls = 0; m_flushes = 0;
    @(posedge clock); #3 reset = 1'b0;
    drive(0, 0, 0, 0, 0, 32'd0, 1, 1);
    @(posedge clock); #1;
    step_expect("rst.after", 6'b0, 0, 0, 0);

    // Randomized run against the reference model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
      step_model($sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
